// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine.
// Operands come from the Y latch and the live bus value; the 64-bit Z pair feeds the bus mux.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             y_in,
    input  logic             start,
    input  logic             op_div,
    output logic [WIDTH-1:0] zhi_output,
    output logic [WIDTH-1:0] zlo_output,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        logic [WIDTH-1:0] r;
        if (n) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return neg_if(v, v[WIDTH-1]);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic             op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_out_q, dbz_out_d;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   hi_n_s;
    logic [WIDTH-1:0] lo_n_s;
    logic             qm1_n_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;

    // One Booth or restoring step; hi carries an extra bit so -2^(W-1) multiplicands cannot overflow.
    always_comb begin
        sum_s     = hi_q;
        shifted_s = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        diff_s    = shifted_s - m_q;
        hi_n_s    = hi_q;
        lo_n_s    = lo_q;
        qm1_n_s   = qm1_q;
        if (op_q) begin
            if (!diff_s[WIDTH]) begin
                hi_n_s = diff_s;
                lo_n_s = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n_s = shifted_s;
                lo_n_s = {lo_q[WIDTH-2:0], 1'b0};
            end
            qm1_n_s = 1'b0;
        end else begin
            case ({lo_q[0], qm1_q})
                2'b01:   sum_s = hi_q + m_q;
                2'b10:   sum_s = hi_q - m_q;
                default: sum_s = hi_q;
            endcase
            {hi_n_s, lo_n_s, qm1_n_s} = {sum_s[WIDTH], sum_s, lo_q};
        end
        quot_s = neg_if(lo_n_s, qneg_q);
        rem_s  = neg_if(hi_n_s[WIDTH-1:0], rneg_q);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qm1_d     = qm1_q;
        op_d      = op_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        zhi_d     = zhi_q;
        zlo_d     = zlo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        if (y_in) begin
            y_d = bus_in;
        end else begin
            y_d = y_q;
        end
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    op_d    = op_div;
                    hi_d    = {(WIDTH+1){1'b0}};
                    qm1_d   = 1'b0;
                    qneg_d  = y_q[WIDTH-1] ^ bus_in[WIDTH-1];
                    rneg_d  = y_q[WIDTH-1];
                    if (op_div) begin
                        m_d   = {1'b0, magnitude(bus_in)};
                        dbz_d = (bus_in == {WIDTH{1'b0}});
                        // A zero divisor keeps the raw dividend so it can be returned as the remainder.
                        if (bus_in == {WIDTH{1'b0}}) begin
                            lo_d = y_q;
                        end else begin
                            lo_d = magnitude(y_q);
                        end
                    end else begin
                        m_d   = {y_q[WIDTH-1], y_q};
                        dbz_d = 1'b0;
                        lo_d  = bus_in;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (dbz_q) begin
                    zhi_d     = lo_q;
                    zlo_d     = {WIDTH{1'b1}};
                    dbz_out_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    hi_d  = hi_n_s;
                    lo_d  = lo_n_s;
                    qm1_d = qm1_n_s;
                    cnt_d = cnt_q + ONE_C;
                    if (cnt_q == LAST_C) begin
                        if (op_q) begin
                            zhi_d = rem_s;
                            zlo_d = quot_s;
                        end else begin
                            zhi_d = hi_n_s[WIDTH-1:0];
                            zlo_d = lo_n_s;
                        end
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; clear aborts everything, including Z.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            y_q       <= {WIDTH{1'b0}};
            m_q       <= {(WIDTH+1){1'b0}};
            hi_q      <= {(WIDTH+1){1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            qm1_q     <= 1'b0;
            op_q      <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            zhi_q     <= {WIDTH{1'b0}};
            zlo_q     <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            qm1_q     <= qm1_d;
            op_q      <= op_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            zhi_q     <= zhi_d;
            zlo_q     <= zlo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign zhi_output  = zhi_q;
    assign zlo_output  = zlo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: expected Z pairs come from a native-operator model.
module tb_mul_div_unit;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic        y_in;
    logic        start;
    logic        op_div;
    logic [31:0] zhi_output;
    logic [31:0] zlo_output;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] zhi;
        logic [31:0] zlo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    logic [31:0] y_model;
    logic [63:0] prev_z;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock       (clock),
        .clear       (clear),
        .bus_in      (bus_in),
        .y_in        (y_in),
        .start       (start),
        .op_div      (op_div),
        .zhi_output  (zhi_output),
        .zlo_output  (zlo_output),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t   e;
        int     sa;
        int     sb;
        longint pa;
        longint pb;
        longint pr;
        sa = a;
        sb = b;
        e.dbz = 1'b0;
        if (!op) begin
            pa = sa;
            pb = sb;
            pr = pa * pb;
            e.zhi = pr[63:32];
            e.zlo = pr[31:0];
        end else if (b == 32'h0000_0000) begin
            e.zhi = a;
            e.zlo = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.zhi = 32'h0000_0000;
            e.zlo = 32'h8000_0000;
        end else begin
            e.zlo = sa / sb;
            e.zhi = sa % sb;
        end
        return e;
    endfunction

    task automatic load_y(input logic [31:0] v);
        y_in   = 1'b1;
        bus_in = v;
        tick();
        y_in    = 1'b0;
        y_model = v;
    endtask

    // Launch one operation, optionally inject a start or Y load mid-run, then check the result.
    task automatic run_op(input string tag, input logic [31:0] b, input logic op, input int lat,
                          input int inj_start, input int inj_y, input logic also_y);
        exp_t e;
        int   cyc;
        int   bcnt;
        e = model(y_model, b, op);
        sb_q.push_back(e);
        bus_in = b;
        op_div = op;
        start  = 1'b1;
        y_in   = also_y;
        tick();
        start = 1'b0;
        y_in  = 1'b0;
        if (also_y) y_model = b;
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            if (cyc == 10) check({tag, "_z_hold_run"}, {zhi_output, zlo_output}, prev_z);
            start  = (cyc == inj_start);
            op_div = ~op;
            y_in   = (cyc == inj_y);
            bus_in = (cyc == inj_y) ? 32'd9 : $urandom;
            if (cyc == inj_y) y_model = 32'd9;
            tick();
            cyc++;
        end
        start = 1'b0;
        y_in  = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(lat));
        e = sb_q.pop_front();
        check({tag, "_z"}, {zhi_output, zlo_output}, {e.zhi, e.zlo});
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        prev_z = {e.zhi, e.zlo};
        tick();
        check({tag, "_done_drop"}, {62'd0, done, div_by_zero}, 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_z_hold_after"}, {zhi_output, zlo_output}, prev_z);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        clear   = 1'b1;
        bus_in  = 32'd0;
        y_in    = 1'b0;
        start   = 1'b0;
        op_div  = 1'b0;
        y_model = 32'd0;
        prev_z  = 64'd0;
        tick();
        tick();
        check("reset_z", {zhi_output, zlo_output}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        clear = 1'b0;
        tick();

        // Y resets to zero, so the first multiply yields zero.
        run_op("y_reset_mul", 32'd5, 1'b0, 32, -1, -1, 1'b0);

        load_y(32'd7);
        run_op("mul_7_m3", 32'hFFFF_FFFD, 1'b0, 32, -1, -1, 1'b0);
        load_y(32'hFFFF_FFEF);
        run_op("div_m17_5", 32'd5, 1'b1, 32, -1, -1, 1'b0);
        load_y(32'd100);
        run_op("div_by_zero", 32'd0, 1'b1, 1, -1, -1, 1'b0);
        load_y(32'h8000_0000);
        run_op("div_min_m1", 32'hFFFF_FFFF, 1'b1, 32, -1, -1, 1'b0);
        run_op("mul_min_min", 32'h8000_0000, 1'b0, 32, -1, -1, 1'b0);
        load_y(32'd1000);
        run_op("div_1000_m7", 32'hFFFF_FFF9, 1'b1, 32, -1, -1, 1'b0);
        load_y(32'hFFFF_FC18);
        run_op("div_m1000_m7", 32'hFFFF_FFF9, 1'b1, 32, -1, -1, 1'b0);
        load_y(32'd7);
        run_op("div_7_100", 32'd100, 1'b1, 32, -1, -1, 1'b0);
        load_y(32'h7FFF_FFFF);
        run_op("mul_max_min", 32'h8000_0000, 1'b0, 32, -1, -1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            load_y($urandom);
            run_op("rand_mul", $urandom, 1'b0, 32, -1, -1, 1'b0);
            load_y($urandom);
            run_op("rand_div", $urandom_range(1, 32'h7FFF_FFFF) ^ {$urandom_range(0, 1) == 1, 31'd0},
                   1'b1, 32, -1, -1, 1'b0);
        end

        // Mid-run start pulses are dropped; a mid-run Y load only changes Y.
        load_y(32'd12345);
        run_op("start_in_run", 32'hFFFF_FD4A, 1'b0, 32, 5, -1, 1'b0);
        load_y(32'd77);
        run_op("y_in_run", 32'd4, 1'b1, 32, -1, 12, 1'b0);
        run_op("y_after_run", 32'd1, 1'b0, 32, -1, -1, 1'b0);

        // start and y_in on the same edge: old Y used, new Y latched.
        load_y(32'd3);
        run_op("start_and_y", 32'd5, 1'b0, 32, -1, -1, 1'b1);
        run_op("new_y_used", 32'd2, 1'b0, 32, -1, -1, 1'b0);

        // Clear at RUN cycle 15 aborts with no done pulse.
        load_y(32'd11);
        bus_in = 32'd13;
        op_div = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        clear = 1'b1;
        #1;
        check("clear_z", {zhi_output, zlo_output}, 64'd0);
        check("clear_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        tick();
        clear   = 1'b0;
        y_model = 32'd0;
        prev_z  = 64'd0;
        y_in    = 1'b1;
        bus_in  = 32'd6;
        tick();
        y_in    = 1'b0;
        y_model = 32'd6;
        for (int i = 0; i < 20; i++) tick();
        check("clear_no_done", {62'd0, done, busy}, 64'd0);
        run_op("mul_6_6", 32'd6, 1'b0, 32, -1, -1, 1'b0);
        check("mul_6_6_value", {zhi_output, zlo_output}, 64'd36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
